// File: rtl/bcd_scan_ctrl.sv
// Four-digit scan controller sharing one external 6-bit binary-to-BCD converter between val_hi and val_lo.
// Optional macro LEADING_ZERO_BLANK_EN blanks the anode of a tens slot whose converted tens digit is zero.
module bcd_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [5:0] val_hi,
    input  logic [5:0] val_lo,
    output logic [5:0] conv_B,
    input  logic [3:0] conv_tens,
    input  logic [3:0] conv_ones,
    output logic [3:0] digit,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_start
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [5:0]    r_snap_hi;
    logic [5:0]    r_snap_lo;
    logic          r_primed;
    logic [3:0]    r_digit;
    logic [3:0]    r_an;
    logic          r_dp;
    logic          r_frame_start;

    logic          w_tick;
    logic          w_load;
    logic [3:0]    w_an_next;

    // Slot tick, snapshot request and next anode pattern for the current slot.
    always_comb begin
        w_tick    = en && (r_cnt == CNT_MAX);
        w_load    = en && (!r_primed || (w_tick && (r_idx == 2'd3)));
        w_an_next = ~(4'b0001 << r_idx);
`ifdef LEADING_ZERO_BLANK_EN
        if (r_idx[0] && (conv_tens == 4'd0)) begin
            w_an_next = 4'b1111;
        end else begin
            w_an_next = ~(4'b0001 << r_idx);
        end
`endif
    end

    // Slot counter and scan index; both freeze while the display is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (en) begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
                r_idx <= r_idx;
            end
        end else begin
            r_cnt <= r_cnt;
            r_idx <= r_idx;
        end
    end

    // Frame snapshot: taken once on first enable, then only at the frame wrap, so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_hi     <= 6'd0;
            r_snap_lo     <= 6'd0;
            r_primed      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_load) begin
                r_snap_hi <= val_hi;
                r_snap_lo <= val_lo;
                r_primed  <= 1'b1;
            end else begin
                r_snap_hi <= r_snap_hi;
                r_snap_lo <= r_snap_lo;
                r_primed  <= r_primed;
            end
            r_frame_start <= w_load;
        end
    end

    // Display output register, one cycle behind the scan index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit <= 4'd0;
            r_an    <= 4'b1111;
            r_dp    <= 1'b1;
        end else if (en) begin
            r_digit <= r_idx[0] ? conv_tens : conv_ones;
            r_an    <= w_an_next;
            r_dp    <= (r_idx == 2'd2) ? 1'b0 : 1'b1;
        end else begin
            r_digit <= r_digit;
            r_an    <= 4'b1111;
            r_dp    <= 1'b1;
        end
    end

    assign conv_B      = r_idx[1] ? r_snap_hi : r_snap_lo;
    assign digit       = r_digit;
    assign an          = r_an;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
- Time-multiplexes one shared 6-bit binary-to-BCD converter between two 6-bit values, val_hi and val_lo. A typical use is mm.ss on a 4-digit seven-segment display.
- Drives the converter's 6-bit input. Captures its tens/ones results.
- Sequences the four active-low anodes and presents one BCD digit per scan slot to the downstream segment decoder.
- Sits between the counter/timekeeping logic and the seven-segment decoder. The converter instance lives outside, in the parent.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. Legal range is 2 or more. At 100 MHz this gives a 1 ms slot and a 4 ms frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  scan enable; 0 = display dark, scan frozen
- val_hi  in  6  left digit pair value, 0..63
- val_lo  in  6  right digit pair value, 0..63
- conv_B  out  6  to converter input B
- conv_tens  in  4  from converter tens output
- conv_ones  in  4  from converter ones output
- digit  out  4  registered BCD digit for the current slot
- an  out  4  registered anode enables, active-low; an[0] = rightmost digit
- dp  out  1  registered decimal point, active-low
- frame_start  out  1  registered one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (synchronous, active-high). On reset:
  - cnt = 0, idx = 0, snap_hi = 0, snap_lo = 0, primed = 0.
  - an = 4'b1111, digit = 0, dp = 1, frame_start = 0.
  - Reset mid-frame aborts the scan. The next scan restarts at idx 0 with a fresh snapshot.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1 while en = 1.
  - tick is asserted when cnt == REFRESH_DIV-1 and en = 1. On tick, cnt returns to 0 and idx increments modulo 4 (3 wraps to 0).
- Snapshot. snap_hi/snap_lo load val_hi/val_lo when either:
  - (a) primed == 0 and en == 1, which also sets primed = 1; or
  - (b) tick occurs with idx == 3, on the same edge that idx wraps to 0.
  - frame_start is 1 in the cycle after either load.
  - Input changes between snapshots never alter the displayed frame (no tearing).
- Converter select, combinational from registers:
  - conv_B = idx[1] ? snap_hi : snap_lo.
- Output register, updated every cycle while en = 1:
  - digit <= idx[0] ? conv_tens : conv_ones
  - an <= ~(4'b0001 << idx)
  - dp <= (idx == 2) ? 0 : 1
- Latency:
  - an, digit and dp lag idx by exactly 1 cycle and stay mutually aligned.
  - The first valid digit appears 2 cycles after the first en = 1 following reset: snapshot, then register.
- Slot mapping: idx0 = lo ones, idx1 = lo tens, idx2 = hi ones (dp lit), idx3 = hi tens.
- en = 0:
  - cnt, idx, snap and primed hold.
  - an <= 4'b1111 and dp <= 1; digit holds.
  - Resuming continues from the held cnt/idx with no re-snapshot, unless primed == 0.
- Simultaneous events:
  - reset has priority over everything.
  - tick with idx == 3 and primed == 0 results in a single snapshot; primed is set.
- Values 60..63 are legal and are displayed as converted, e.g. 63 shows "63".

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in tens slots (idx 1, 3), when conv_tens == 0 the anode for that slot stays off (an bit = 1). Digit and dp timing are unchanged. Example: val_lo = 5 lights only an[0].
- Undefined: all four anodes always light in turn; a zero tens digit shows "0".

Test Plan:
- REFRESH_DIV = 4, reset held 3 cycles -> an = 1111, digit = 0, dp = 1, frame_start = 0 throughout; conv_B = 0.
- val_hi = 37, val_lo = 45, en = 1 after reset -> frame_start pulse, then:
  - slot 0: an = 1110, digit = 5, dp = 1
  - slot 1: an = 1101, digit = 4
  - slot 2: an = 1011, digit = 7, dp = 0
  - slot 3: an = 0111, digit = 3
  - each slot lasts 4 cycles; slot 0 repeats after 16 cycles.
- val_lo changed from 45 to 12 during slot 1 -> the current frame still shows 4/7/3. The next frame shows 2, 1 in slots 0/1, with frame_start pulsed at the wrap.
- en dropped for 10 cycles mid-slot 2 -> an = 1111 and dp = 1 one cycle later, idx/cnt frozen. On resume, slot 2 completes its remaining cycles and then slot 3 follows.
- val_hi = 63, val_lo = 0 -> slots show 0, 0, 3, 6. With LEADING_ZERO_BLANK_EN defined, slot 1 keeps an = 1111 while the other slots are unchanged.
- reset asserted during slot 3 -> next cycle all outputs are at reset values. After release with en = 1, a new snapshot is taken and the scan restarts at slot 0.
